uart_param_fifo: RTL and testbench
==================================

Name: uart_param_fifo

Overview:
- Parametrised synchronous FIFO for the UART TX/RX datapaths. It generalises the byte FIFO with configurable width and depth.
- Provides a true pointer-based full flag, an occupancy count, and programmable almost-full and almost-empty thresholds.
- Provides sticky overflow and underflow error flags, a synchronous flush, and a selectable first-word-fall-through (FWFT) read mode.
- Sits between the bus/register interface and the UART TX serializer, or between the RX deserializer and the bus.

Parameters:
- DATA_WIDTH, 8, width of each stored word.
- DEPTH, 32, number of entries; must be a power of two and at least 2.
- FWFT, 0, read mode: 0 = registered read with 1-cycle latency; 1 = head word visible on rd_data while not empty.
- AF_THRESH, DEPTH-4, almost_full asserts when count >= AF_THRESH.
- AE_THRESH, 4, almost_empty asserts when count <= AE_THRESH.
- PTR_WIDTH, $clog2(DEPTH), derived; do not override.

Ports:
- clk  input  1  system clock, rising edge.
- rstn  input  1  asynchronous active-low reset.
- flush  input  1  synchronous clear of the contents.
- wr_en  input  1  write request.
- wr_data  input  DATA_WIDTH  write word.
- rd_en  input  1  read request (pop).
- rd_data  output  DATA_WIDTH  read word.
- rd_valid  output  1  rd_data holds a valid popped word (FWFT=0) or a valid head word (FWFT=1).
- full  output  1  count == DEPTH.
- empty  output  1  count == 0.
- almost_full  output  1  count >= AF_THRESH.
- almost_empty  output  1  count <= AE_THRESH.
- count  output  PTR_WIDTH+1  current occupancy, range 0..DEPTH.
- overflow  output  1  sticky: a write was dropped.
- underflow  output  1  sticky: a read was rejected.
- clr_err  input  1  clears overflow and underflow.

Behaviour:
- Reset (rstn low, asynchronous):
  - wr_ptr = 0, rd_ptr = 0, count = 0.
  - rd_data = 0, rd_valid = 0, overflow = 0, underflow = 0.
  - empty = 1, full = 0, almost_empty = 1, almost_full = 0.
  - Memory contents are not reset.
  - Reset mid-operation discards all contents. The first cycle after release behaves as an empty FIFO.
- Pointers:
  - wr_ptr and rd_ptr are PTR_WIDTH+1 bits; the memory index is the low PTR_WIDTH bits.
  - Pointers wrap naturally modulo 2*DEPTH.
  - full = (MSBs differ) and (low bits equal). empty = (pointers equal).
- Accept rules, evaluated on the same edge:
  - rd_acc = rd_en & !empty.
  - wr_acc = wr_en & (!full | rd_acc).
  - Write-while-full is accepted only when a read is accepted in the same cycle.
  - Read-while-empty is always rejected, including when a write occurs in the same cycle; the written word becomes readable next cycle.
- count:
  - +1 on wr_acc only; -1 on rd_acc only; unchanged when both or neither occur.
  - Registered; updates on the same edge as the pointers.
  - Flags are combinational from the registered state.
- FWFT=0:
  - On rd_acc, rd_data <= mem[rd_ptr] and rd_valid <= 1 for exactly one cycle.
  - Otherwise rd_valid <= 0 and rd_data holds its last value.
  - Read latency is 1 cycle.
- FWFT=1:
  - rd_data = mem[rd_ptr] (combinational) and rd_valid = !empty.
  - rd_en acknowledges and pops the current head.
  - Write-to-visible latency is 1 cycle.
- Errors:
  - overflow <= 1 on wr_en & !wr_acc; underflow <= 1 on rd_en & !rd_acc.
  - clr_err clears both flags. A set in the same cycle as clr_err wins.
- flush:
  - Has priority over wr_en and rd_en in the same cycle.
  - Next state: pointers 0, count 0, rd_valid 0.
  - Error flags are unaffected by flush, and flush does not generate errors.
- Write is not edge-detected: each cycle with wr_en high attempts one write.

Test Plan:
- Reset, then 5 writes (0x11..0x15), then 5 reads with FWFT=0 -> rd_data 0x11..0x15, each one cycle after its rd_en; rd_valid pulses; count 5→0; empty=1 at end.
- 32 writes (0x00..0x1F) -> full=1 and count=32 after the 32nd edge; almost_full rises when count reaches 28. A 33rd write of 0xAA is dropped and overflow=1; the read-back sequence is 0x00..0x1F.
- With the FIFO full, wr_en and rd_en in the same cycle (write 0x5A) -> both accepted; count stays 32; no overflow; 0x5A is the last word read.
- With the FIFO empty, rd_en and wr_en (0x33) in the same cycle -> read rejected and underflow=1. Next cycle count=1; a following read returns 0x33. clr_err then clears underflow.
- FWFT=1: write 0x7E -> next cycle rd_valid=1 and rd_data=0x7E without rd_en. rd_en pops it; rd_valid=0 when empty.
- Write 10 words, 3 reads with wrap over 40 total writes, then flush -> count=0 and empty=1 next cycle; overflow and underflow unchanged. Assert rstn low mid-burst -> all outputs at their reset values immediately.

Source files
------------

// File: rtl/uart_param_fifo.sv
// uart_param_fifo
//   Parametrised synchronous FIFO for the UART TX/RX datapaths. It has
//   pointer-based full/empty detection, an occupancy count, programmable
//   almost-full/almost-empty thresholds, sticky overflow/underflow flags,
//   a synchronous flush and an optional first-word-fall-through read port.
//
// Ports
//   clk          system clock, rising edge
//   rstn         asynchronous active-low reset
//   flush        synchronous clear of the contents (beats wr_en/rd_en)
//   wr_en        write request, one attempt per cycle while high
//   wr_data      write word
//   rd_en        read request (pop)
//   rd_data      read word (registered when FWFT=0, head word when FWFT=1)
//   rd_valid     rd_data holds a popped word (FWFT=0) / a head word (FWFT=1)
//   full, empty  occupancy == DEPTH / occupancy == 0
//   almost_full  count >= AF_THRESH
//   almost_empty count <= AE_THRESH
//   count        occupancy, 0..DEPTH
//   overflow     sticky: a write was dropped
//   underflow    sticky: a read was rejected
//   clr_err      clears overflow and underflow (a same-cycle set wins)
module uart_param_fifo #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 32,
  parameter int FWFT       = 0,
  parameter int AF_THRESH  = DEPTH - 4,
  parameter int AE_THRESH  = 4,
  parameter int PTR_WIDTH  = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  flush,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_valid,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic [PTR_WIDTH:0]    count,
  output logic                  overflow,
  output logic                  underflow,
  input  logic                  clr_err
);

  localparam int                CW     = PTR_WIDTH + 1;
  localparam logic [PTR_WIDTH:0] ONE   = CW'(1);
  localparam logic [PTR_WIDTH:0] AF_LVL = CW'(AF_THRESH);
  localparam logic [PTR_WIDTH:0] AE_LVL = CW'(AE_THRESH);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [PTR_WIDTH:0]    wr_ptr;
  logic [PTR_WIDTH:0]    rd_ptr;
  logic [PTR_WIDTH:0]    count_q;
  logic                  rd_acc;
  logic                  wr_acc;
  logic                  ovf_q;
  logic                  udf_q;

  // Pointers carry one extra wrap bit: same index with differing wrap bits
  // means the write side is a full lap ahead.
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[PTR_WIDTH] != rd_ptr[PTR_WIDTH]) &&
                 (wr_ptr[PTR_WIDTH-1:0] == rd_ptr[PTR_WIDTH-1:0]);

  // A write into a full FIFO is fine when the head leaves on the same edge.
  assign rd_acc = rd_en & ~empty;
  assign wr_acc = wr_en & (~full | rd_acc);

  assign count        = count_q;
  assign almost_full  = (count_q >= AF_LVL);
  assign almost_empty = (count_q <= AE_LVL);
  assign overflow     = ovf_q;
  assign underflow    = udf_q;

  // Stage p0: storage write (contents are never reset)
  always_ff @(posedge clk) begin
    if (wr_acc && !flush) begin
      mem[wr_ptr[PTR_WIDTH-1:0]] <= wr_data;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else if (flush) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (wr_acc) wr_ptr <= wr_ptr + ONE;
      if (rd_acc) rd_ptr <= rd_ptr + ONE;
      if (wr_acc && !rd_acc)      count_q <= count_q + ONE;
      else if (rd_acc && !wr_acc) count_q <= count_q - ONE;
    end
  end

  // Sticky error flags; the set terms come after the clear so a new error
  // in the clearing cycle survives. A flush cycle never raises an error.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      ovf_q <= 1'b0;
      udf_q <= 1'b0;
    end else begin
      if (clr_err) begin
        ovf_q <= 1'b0;
        udf_q <= 1'b0;
      end
      if (!flush && wr_en && !wr_acc) ovf_q <= 1'b1;
      if (!flush && rd_en && !rd_acc) udf_q <= 1'b1;
    end
  end

  generate
    if (FWFT == 0) begin : g_reg_rd
      logic [DATA_WIDTH-1:0] rd_data_p1;
      logic                  vld_p1;

      // Stage p1: registered read port, one-cycle valid pulse per pop
      always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
          rd_data_p1 <= '0;
          vld_p1     <= 1'b0;
        end else if (flush) begin
          vld_p1 <= 1'b0;
        end else if (rd_acc) begin
          rd_data_p1 <= mem[rd_ptr[PTR_WIDTH-1:0]];
          vld_p1     <= 1'b1;
        end else begin
          vld_p1 <= 1'b0;
        end
      end

      assign rd_data  = rd_data_p1;
      assign rd_valid = vld_p1;
    end else begin : g_fwft_rd
      // Head word shown directly; forced to zero while empty so the port
      // reads as zero out of reset even though storage is not cleared.
      assign rd_data  = empty ? '0 : mem[rd_ptr[PTR_WIDTH-1:0]];
      assign rd_valid = ~empty;
    end
  endgenerate

endmodule

// File: tb/tb_uart_param_fifo.sv
module tb_uart_param_fifo;

  localparam int DW = 8;
  localparam int DP = 32;

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic          flush = 1'b0;
  logic          wr_en = 1'b0;
  logic [DW-1:0] wr_data = '0;
  logic          rd_en = 1'b0;
  logic          clr_err = 1'b0;

  logic [DW-1:0] rd_data0, rd_data1;
  logic          rd_valid0, rd_valid1, full0, full1, empty0, empty1;
  logic          af0, af1, ae0, ae1, ovf0, ovf1, udf0, udf1;
  logic [5:0]    count0, count1;

  int n_checks = 0;
  int n_fail   = 0;

  // reference model state
  logic [DW-1:0] q[$];
  logic [DW-1:0] m_data;
  logic          m_vld;
  logic          m_ovf;
  logic          m_udf;

  always #5 clk = ~clk;

  uart_param_fifo #(.DATA_WIDTH(DW), .DEPTH(DP), .FWFT(0)) u0 (
    .clk(clk), .rstn(rstn), .flush(flush), .wr_en(wr_en), .wr_data(wr_data),
    .rd_en(rd_en), .rd_data(rd_data0), .rd_valid(rd_valid0), .full(full0),
    .empty(empty0), .almost_full(af0), .almost_empty(ae0), .count(count0),
    .overflow(ovf0), .underflow(udf0), .clr_err(clr_err));

  uart_param_fifo #(.DATA_WIDTH(DW), .DEPTH(DP), .FWFT(1)) u1 (
    .clk(clk), .rstn(rstn), .flush(flush), .wr_en(wr_en), .wr_data(wr_data),
    .rd_en(rd_en), .rd_data(rd_data1), .rd_valid(rd_valid1), .full(full1),
    .empty(empty1), .almost_full(af1), .almost_empty(ae1), .count(count1),
    .overflow(ovf1), .underflow(udf1), .clr_err(clr_err));

  function automatic logic [20:0] pack(logic [7:0] d, logic v, logic f, logic e,
                                       logic af, logic ae, logic [5:0] c,
                                       logic ov, logic un);
    return {d, v, f, e, af, ae, c, ov, un};
  endfunction

  function automatic logic [41:0] obs_vec();
    return {pack(rd_data0, rd_valid0, full0, empty0, af0, ae0, count0, ovf0, udf0),
            pack(rd_data1, rd_valid1, full1, empty1, af1, ae1, count1, ovf1, udf1)};
  endfunction

  function automatic logic [41:0] exp_vec();
    int sz;
    logic [7:0] head;
    sz   = q.size();
    head = (sz != 0) ? q[0] : 8'h00;
    return {pack(m_data, m_vld, sz == DP, sz == 0, sz >= DP - 4, sz <= 4, 6'(sz), m_ovf, m_udf),
            pack(head, sz != 0, sz == DP, sz == 0, sz >= DP - 4, sz <= 4, 6'(sz), m_ovf, m_udf)};
  endfunction

  task automatic model_reset();
    q.delete();
    m_data = '0;
    m_vld  = 1'b0;
    m_ovf  = 1'b0;
    m_udf  = 1'b0;
  endtask

  // Queue-level behaviour of one clock edge with the current inputs.
  task automatic model_step();
    bit racc, wacc;
    if (flush) begin
      q.delete();
      m_vld = 1'b0;
      if (clr_err) begin m_ovf = 1'b0; m_udf = 1'b0; end
    end else begin
      racc = rd_en && (q.size() > 0);
      wacc = wr_en && ((q.size() < DP) || racc);
      if (racc) begin m_data = q.pop_front(); m_vld = 1'b1; end
      else m_vld = 1'b0;
      if (wacc) q.push_back(wr_data);
      if (clr_err) begin m_ovf = 1'b0; m_udf = 1'b0; end
      if (wr_en && !wacc) m_ovf = 1'b1;
      if (rd_en && !racc) m_udf = 1'b1;
    end
  endtask

  task automatic drive(input logic w, input logic [7:0] d, input logic r,
                       input logic f, input logic c);
    wr_en = w; wr_data = d; rd_en = r; flush = f; clr_err = c;
  endtask

  task automatic tick();
    @(posedge clk);
    if (rstn) model_step();
    #1;
  endtask

  task automatic do_reset();
    drive(0, 8'h00, 0, 0, 0);
    rstn = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1 rstn = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++;
    if (obs_vec() !== exp_vec()) begin
      n_fail++;
      $display("FAIL reset_state got %h want %h", obs_vec(), exp_vec());
    end
  endtask

  task automatic test_basic();
    for (int i = 0; i < 5; i++) begin
      drive(1, 8'h11 + 8'(i), 0, 0, 0);
      tick();
      n_checks++;
      if (obs_vec() !== exp_vec()) begin
        n_fail++;
        $display("FAIL basic_wr%0d got %h want %h", i, obs_vec(), exp_vec());
      end
    end
    for (int i = 0; i < 5; i++) begin
      drive(0, 8'h00, 1, 0, 0);
      tick();
      n_checks++;
      if (rd_data0 !== 8'h11 + 8'(i) || rd_valid0 !== 1'b1 || count0 !== 6'(4 - i)) begin
        n_fail++;
        $display("FAIL basic_rd%0d got d=%h v=%b c=%0d want d=%h v=1 c=%0d",
                 i, rd_data0, rd_valid0, count0, 8'h11 + 8'(i), 4 - i);
      end
    end
    drive(0, 8'h00, 0, 0, 0);
    tick();
    n_checks++;
    if (rd_valid0 !== 1'b0 || empty0 !== 1'b1 || obs_vec() !== exp_vec()) begin
      n_fail++;
      $display("FAIL basic_end got %h want %h", obs_vec(), exp_vec());
    end
  endtask

  task automatic test_overflow();
    for (int i = 0; i < DP; i++) begin
      drive(1, 8'(i), 0, 0, 0);
      tick();
      n_checks++;
      if (af0 !== (i + 1 >= 28) || obs_vec() !== exp_vec()) begin
        n_fail++;
        $display("FAIL fill%0d got af=%b %h want af=%b %h", i, af0, obs_vec(),
                 (i + 1 >= 28), exp_vec());
      end
    end
    drive(1, 8'hAA, 0, 0, 0);
    tick();
    n_checks++;
    if (ovf0 !== 1'b1 || ovf1 !== 1'b1 || count0 !== 6'd32 || full0 !== 1'b1) begin
      n_fail++;
      $display("FAIL overflow got ovf=%b/%b c=%0d full=%b want 1/1 32 1",
               ovf0, ovf1, count0, full0);
    end
    for (int i = 0; i < DP; i++) begin
      drive(0, 8'h00, 1, 0, 0);
      tick();
      n_checks++;
      if (rd_data0 !== 8'(i) || obs_vec() !== exp_vec()) begin
        n_fail++;
        $display("FAIL ovf_readback%0d got %h want %h", i, rd_data0, 8'(i));
      end
    end
    drive(0, 8'h00, 0, 0, 1);
    tick();
    drive(0, 8'h00, 0, 0, 0);
    n_checks++;
    if (ovf0 !== 1'b0 || obs_vec() !== exp_vec()) begin
      n_fail++;
      $display("FAIL ovf_clear got %h want %h", obs_vec(), exp_vec());
    end
  endtask

  task automatic test_full_rw();
    for (int i = 0; i < DP; i++) begin
      drive(1, 8'($urandom_range(0, 255)), 0, 0, 0);
      tick();
    end
    drive(1, 8'h5A, 1, 0, 0);
    tick();
    n_checks++;
    if (count0 !== 6'd32 || ovf0 !== 1'b0 || full0 !== 1'b1 || obs_vec() !== exp_vec()) begin
      n_fail++;
      $display("FAIL full_rw got c=%0d ovf=%b %h want c=32 ovf=0 %h",
               count0, ovf0, obs_vec(), exp_vec());
    end
    for (int i = 0; i < DP; i++) begin
      drive(0, 8'h00, 1, 0, 0);
      tick();
      n_checks++;
      if (obs_vec() !== exp_vec()) begin
        n_fail++;
        $display("FAIL full_rw_rd%0d got %h want %h", i, obs_vec(), exp_vec());
      end
    end
    n_checks++;
    if (rd_data0 !== 8'h5A || empty0 !== 1'b1) begin
      n_fail++;
      $display("FAIL full_rw_last got %h empty=%b want 5a empty=1", rd_data0, empty0);
    end
    drive(0, 8'h00, 0, 0, 0);
    tick();
  endtask

  task automatic test_empty_rw();
    drive(1, 8'h33, 1, 0, 0);
    tick();
    n_checks++;
    if (udf0 !== 1'b1 || udf1 !== 1'b1 || count0 !== 6'd1 || rd_valid0 !== 1'b0) begin
      n_fail++;
      $display("FAIL empty_rw got udf=%b/%b c=%0d v=%b want 1/1 1 0",
               udf0, udf1, count0, rd_valid0);
    end
    drive(0, 8'h00, 1, 0, 0);
    tick();
    n_checks++;
    if (rd_data0 !== 8'h33 || rd_valid0 !== 1'b1 || obs_vec() !== exp_vec()) begin
      n_fail++;
      $display("FAIL empty_rw_rd got %h want 33", rd_data0);
    end
    drive(0, 8'h00, 0, 0, 1);
    tick();
    drive(0, 8'h00, 0, 0, 0);
    n_checks++;
    if (udf0 !== 1'b0 || udf1 !== 1'b0) begin
      n_fail++;
      $display("FAIL udf_clear got %b/%b want 0/0", udf0, udf1);
    end
    // a new error in the clearing cycle must survive the clear
    drive(0, 8'h00, 1, 0, 1);
    tick();
    drive(0, 8'h00, 0, 0, 0);
    n_checks++;
    if (udf0 !== 1'b1 || obs_vec() !== exp_vec()) begin
      n_fail++;
      $display("FAIL set_beats_clear got udf=%b want 1", udf0);
    end
    drive(0, 8'h00, 0, 0, 1);
    tick();
    drive(0, 8'h00, 0, 0, 0);
  endtask

  task automatic test_fwft();
    drive(1, 8'h7E, 0, 0, 0);
    tick();
    drive(0, 8'h00, 0, 0, 0);
    n_checks++;
    if (rd_valid1 !== 1'b1 || rd_data1 !== 8'h7E || rd_valid0 !== 1'b0) begin
      n_fail++;
      $display("FAIL fwft_show got v=%b d=%h (reg v=%b) want 1 7e (0)",
               rd_valid1, rd_data1, rd_valid0);
    end
    drive(0, 8'h00, 1, 0, 0);
    tick();
    drive(0, 8'h00, 0, 0, 0);
    n_checks++;
    if (rd_valid1 !== 1'b0 || empty1 !== 1'b1 || obs_vec() !== exp_vec()) begin
      n_fail++;
      $display("FAIL fwft_pop got v=%b e=%b want 0 1", rd_valid1, empty1);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      drive($urandom_range(0, 99) < 55, 8'($urandom_range(0, 255)),
            $urandom_range(0, 99) < 45, $urandom_range(0, 99) < 2,
            $urandom_range(0, 99) < 4);
      tick();
      n_checks++;
      if (obs_vec() !== exp_vec()) begin
        n_fail++;
        $display("FAIL random%0d got %h want %h", i, obs_vec(), exp_vec());
      end
    end
    drive(0, 8'h00, 0, 0, 0);
  endtask

  task automatic test_flush();
    for (int i = 0; i < 40; i++) begin
      drive(1, 8'(8'h40 + i), (i % 4) == 3, 0, 0);
      tick();
    end
    drive(1, 8'h00, 0, 0, 0);
    tick(); // plus overflow if full
    drive(0, 8'h00, 1, 1, 0);
    tick();
    n_checks++;
    if (count0 !== 6'd0 || empty0 !== 1'b1 || rd_valid0 !== 1'b0 || obs_vec() !== exp_vec()) begin
      n_fail++;
      $display("FAIL flush got %h want %h", obs_vec(), exp_vec());
    end
    // flush with requests never raises errors
    drive(1, 8'h99, 1, 1, 0);
    tick();
    drive(0, 8'h00, 0, 0, 0);
    n_checks++;
    if (udf0 !== m_udf || ovf0 !== m_ovf || empty1 !== 1'b1 || obs_vec() !== exp_vec()) begin
      n_fail++;
      $display("FAIL flush_noerr got %h want %h", obs_vec(), exp_vec());
    end
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 7; i++) begin
      drive(1, 8'($urandom_range(0, 255)), i == 4, 0, 0);
      tick();
    end
    drive(0, 8'h00, 1, 0, 0);
    tick();
    #2 rstn = 1'b0;
    model_reset();
    #1;
    n_checks++;
    if (obs_vec() !== exp_vec()) begin
      n_fail++;
      $display("FAIL async_reset got %h want %h", obs_vec(), exp_vec());
    end
    drive(0, 8'h00, 0, 0, 0);
    @(negedge clk);
    rstn = 1'b1;
    drive(1, 8'hC3, 1, 0, 0);
    tick();
    drive(0, 8'h00, 0, 0, 0);
    n_checks++;
    if (udf0 !== 1'b1 || count0 !== 6'd1 || rd_data1 !== 8'hC3 || obs_vec() !== exp_vec()) begin
      n_fail++;
      $display("FAIL after_reset got %h want %h", obs_vec(), exp_vec());
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_basic();
    test_overflow();
    test_full_rw();
    test_empty_rw();
    test_fwft();
    test_random();
    test_flush();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
